// File: rtl/div_iter_if.sv
// Handshake and data bundle for the iterative divider.
//
// Handshake: the requester raises start for one or more cycles with operands
// and flag_unsigned valid; the request is taken on a rising edge only when the
// divider is in IDLE or DONE (busy=0). While busy=1, start is ignored, not
// queued. done pulses for exactly one cycle when result/div_by_zero become
// valid, and both stay held until the next accepted start loads new values.
// cancel wins over start in the same cycle and returns the divider to IDLE
// without a done pulse.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 cancel;
    logic                 flag_unsigned;
    logic [WIDTH-1:0]     operand1;
    logic [WIDTH-1:0]     operand2;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [2:0]           dbg_state;

    // Requester side (EX stage / testbench).
    modport master (
        output start, cancel, flag_unsigned, operand1, operand2,
        input  result, busy, done, div_by_zero, dbg_state
    );

    // Divider side.
    modport slave (
        input  start, cancel, flag_unsigned, operand1, operand2,
        output result, busy, done, div_by_zero, dbg_state
    );
endinterface

// File: rtl/div_iter.sv
// Multi-cycle restoring radix-2 integer divider, one quotient bit per cycle.
// Signed and unsigned modes, divide-by-zero flag, cancel on pipeline flush.
// result = {remainder, quotient}, held until the next accepted start.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    div_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    // Operands captured on the accepting edge; the requester may change its
    // inputs afterwards.
    logic [WIDTH-1:0]   op1_q;
    logic [WIDTH-1:0]   op2_q;
    logic               unsigned_q;

    // Working registers. dvd_q shifts the dividend out at the top while the
    // quotient bits shift in at the bottom.
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   rem_q;
    logic [CW-1:0]      count_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic               dbz_q;

    logic [2*WIDTH-1:0] result_q;
    logic               div_by_zero_q;

    // Control strobes from the next-state logic.
    logic               accept;
    logic               load_result;

    // Per-cycle datapath values. The working remainder is WIDTH+1 bits so the
    // trial subtract keeps its borrow.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               rem_ge;
    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; cancel overrides everything, including a start.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        load_result = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_PREP;
                    accept  = 1'b1;
                end
            end
            S_PREP: begin
                state_d = (op2_q == '0) ? S_FIX : S_CALC;
            end
            S_CALC: begin
                if (count_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d     = S_DONE;
                load_result = 1'b1;
            end
            S_DONE: begin
                if (bus.start) begin
                    state_d = S_PREP;
                    accept  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus.cancel) begin
            state_d     = S_IDLE;
            accept      = 1'b0;
            load_result = 1'b0;
        end
    end

    // Datapath helpers: operand signs, trial subtract and sign fix-up.
    always_comb begin
        sign1     = ~unsigned_q & op1_q[WIDTH-1];
        sign2     = ~unsigned_q & op2_q[WIDTH-1];
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        rem_ge    = ~rem_diff[WIDTH];
        quo_fixed = neg_quo_q ? negate(dvd_q) : dvd_q;
        rem_fixed = neg_rem_q ? negate(rem_q) : rem_q;
    end

    // Operand capture and the iterative divide datapath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op1_q      <= '0;
            op2_q      <= '0;
            unsigned_q <= 1'b0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            count_q    <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            if (accept) begin
                op1_q      <= bus.operand1;
                op2_q      <= bus.operand2;
                unsigned_q <= bus.flag_unsigned;
            end
            case (state_q)
                S_PREP: begin
                    // Magnitudes are modulo 2^WIDTH, so |MIN| stays MIN and
                    // is then treated as unsigned by the iteration.
                    dvd_q     <= sign1 ? negate(op1_q) : op1_q;
                    dvs_q     <= sign2 ? negate(op2_q) : op2_q;
                    rem_q     <= '0;
                    count_q   <= CW'(WIDTH - 1);
                    neg_quo_q <= sign1 ^ sign2;
                    neg_rem_q <= sign1;
                    dbz_q     <= (op2_q == '0);
                end
                S_CALC: begin
                    rem_q <= rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    dvd_q <= {dvd_q[WIDTH-2:0], rem_ge};
                    if (count_q != '0) begin
                        count_q <= count_q - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result and divide-by-zero flag, loaded together in FIX and then held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q      <= '0;
            div_by_zero_q <= 1'b0;
        end else if (load_result) begin
            if (dbz_q) begin
                result_q <= {op1_q, {WIDTH{1'b1}}};
            end else begin
                result_q <= {rem_fixed, quo_fixed};
            end
            div_by_zero_q <= dbz_q;
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        bus.result      = result_q;
        bus.div_by_zero = div_by_zero_q;
        bus.busy        = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
        bus.done        = (state_q == S_DONE);
        bus.dbg_state   = state_q;
    end
endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter with hand-computed expected results.
module tb_div_iter;
    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*W-1:0] exp_q[$];

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_start(input logic fu, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start         = 1'b1;
        bus.flag_unsigned = fu;
        bus.operand1      = a;
        bus.operand2      = b;
        tick();
        bus.start         = 1'b0;
    endtask

    // Counts cycles until done, bounded; lat==100 means it never came.
    task automatic wait_done(output int lat, output int busy_low);
        lat      = 0;
        busy_low = 0;
        while (!bus.done && lat < 100) begin
            if (!bus.busy) busy_low++;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic fu, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp_res,
                          input logic exp_dbz, input int exp_lat);
        int lat;
        int busy_low;
        logic [2*W-1:0] e;
        exp_q.push_back(exp_res);
        drive_start(fu, a, b);
        wait_done(lat, busy_low);
        e = exp_q.pop_front();
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, busy_low, 0);
        check({tag, "_res"}, bus.result, e);
        check({tag, "_dbz"}, bus.div_by_zero, exp_dbz);
        tick();
        check({tag, "_done_drop"}, bus.done, 0);
        check({tag, "_hold"}, bus.result, e);
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        int lat;
        int busy_low;
        int saw_done;
        logic [2*W-1:0] prev;

        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.cancel        = 1'b0;
        bus.flag_unsigned = 1'b0;
        bus.operand1      = '0;
        bus.operand2      = '0;
        repeat (2) tick();
        check("rst_result", bus.result, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_state", bus.dbg_state, 0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Main function.
        run_op("u100_7",   1'b1, 32'd100,        32'd7,          {32'd2, 32'd14},               1'b0, 34);
        run_op("s_m7_2",   1'b0, 32'hFFFFFFF9,   32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD},  1'b0, 34);
        run_op("u_m7_2",   1'b1, 32'hFFFFFFF9,   32'h2,          {32'h1, 32'h7FFFFFFC},         1'b0, 34);
        run_op("s_7_m2",   1'b0, 32'd7,          32'hFFFFFFFE,   {32'h1, 32'hFFFFFFFD},         1'b0, 34);
        run_op("s_m8_m3",  1'b0, 32'hFFFFFFF8,   32'hFFFFFFFD,   {32'hFFFFFFFE, 32'h2},         1'b0, 34);
        run_op("u_max_1",  1'b1, 32'hFFFFFFFF,   32'h1,          {32'h0, 32'hFFFFFFFF},         1'b0, 34);
        run_op("s_min_m1", 1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000},         1'b0, 34);
        run_op("s_5_0",    1'b0, 32'd5,          32'd0,          {32'h5, 32'hFFFFFFFF},         1'b1, 2);
        run_op("u_5_0",    1'b1, 32'd5,          32'd0,          {32'h5, 32'hFFFFFFFF},         1'b1, 2);

        // Cancel mid-operation: no done, result and flag held.
        prev = {32'h5, 32'hFFFFFFFF};
        drive_start(1'b1, 32'd100, 32'd7);
        repeat (9) tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cancel_busy", bus.busy, 0);
        check("cancel_state", bus.dbg_state, 0);
        check("cancel_res", bus.result, prev);
        check("cancel_dbz", bus.div_by_zero, 1);
        saw_done = 0;
        repeat (40) begin
            tick();
            if (bus.done) saw_done = 1;
        end
        check("cancel_no_done", saw_done, 0);

        // Asynchronous reset mid-operation clears outputs at once.
        drive_start(1'b1, 32'd100, 32'd7);
        repeat (9) tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_res", bus.result, 0);
        check("arst_dbz", bus.div_by_zero, 0);
        @(negedge clock);
        reset = 1'b0;
        saw_done = 0;
        repeat (40) begin
            tick();
            if (bus.done) saw_done = 1;
        end
        check("arst_no_done", saw_done, 0);

        // start together with cancel in IDLE is dropped.
        bus.start    = 1'b1;
        bus.cancel   = 1'b1;
        bus.operand1 = 32'd9;
        bus.operand2 = 32'd3;
        tick();
        bus.start    = 1'b0;
        bus.cancel   = 1'b0;
        check("cxl_start_busy", bus.busy, 0);
        check("cxl_start_state", bus.dbg_state, 0);

        // start while busy is ignored; operands may change after acceptance.
        drive_start(1'b1, 32'd100, 32'd7);
        repeat (4) tick();
        bus.start         = 1'b1;
        bus.flag_unsigned = 1'b0;
        bus.operand1      = 32'd9;
        bus.operand2      = 32'd3;
        tick();
        bus.start    = 1'b0;
        bus.operand1 = 32'hDEADBEEF;
        bus.operand2 = 32'h0;
        wait_done(lat, busy_low);
        check("busy_start_lat", lat + 5, 34);
        check("busy_start_res", bus.result, {32'd2, 32'd14});

        // Back-to-back: start accepted in the DONE cycle.
        bus.start         = 1'b1;
        bus.flag_unsigned = 1'b1;
        bus.operand1      = 32'd1000;
        bus.operand2      = 32'd10;
        tick();
        bus.start = 1'b0;
        check("b2b_done_drop", bus.done, 0);
        check("b2b_busy", bus.busy, 1);
        wait_done(lat, busy_low);
        check("b2b_lat", lat, 34);
        check("b2b_res", bus.result, {32'd0, 32'd100});
        check("b2b_dbz", bus.div_by_zero, 0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
